// File: rtl/tl_mem_slave_pkg.sv
// Shared TileLink-UL widths, opcodes and the registered D-channel response record
// for the memory slave.
package tl_mem_slave_pkg;
   localparam int TL_DATA_BYTES  = 4;
   localparam int TL_ADDR_BITS   = 32;
   localparam int TL_SIZE_BITS   = 3;
   localparam int TL_SOURCE_BITS = 4;
   localparam int TL_SINK_BITS   = 2;

   localparam logic [2:0] A_PUT_FULL    = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] A_GET         = 3'd4;

   localparam logic [3:0] D_ACCESS_ACK      = 4'd0;
   localparam logic [3:0] D_ACCESS_ACK_DATA = 4'd1;

   typedef struct packed {
      logic [3:0]                  opcode;
      logic [TL_SIZE_BITS-1:0]     size;
      logic [TL_SOURCE_BITS-1:0]   source;
      logic                        denied;
      logic [TL_DATA_BYTES*8-1:0]  data;
   } d_resp_t;

   function automatic logic is_put(input logic [2:0] op);
      return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
   endfunction
endpackage

// File: rtl/tl_mem_slave_if.sv
// Channel A / Channel D signal bundle between a TileLink-UL master and the memory slave.
interface tl_mem_slave_if;
   import tl_mem_slave_pkg::*;

   logic                        a_valid;
   logic                        a_ready;
   logic [2:0]                  a_opcode;
   logic [2:0]                  a_param;
   logic [TL_SIZE_BITS-1:0]     a_size;
   logic [TL_SOURCE_BITS-1:0]   a_source;
   logic [TL_ADDR_BITS-1:0]     a_address;
   logic [TL_DATA_BYTES-1:0]    a_mask;
   logic [TL_DATA_BYTES*8-1:0]  a_data;

   logic                        d_valid;
   logic                        d_ready;
   logic [3:0]                  d_opcode;
   logic [1:0]                  d_param;
   logic [TL_SIZE_BITS-1:0]     d_size;
   logic [TL_SOURCE_BITS-1:0]   d_source;
   logic [TL_SINK_BITS-1:0]     d_sink;
   logic                        d_denied;
   logic [TL_DATA_BYTES*8-1:0]  d_data;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
   );
endinterface

// File: rtl/tl_mem_bytewrite_ram.sv
// Word-organised memory built from one byte-wide array per lane: per-byte write
// enables, combinational read, no reset so it maps onto RAM primitives.
module tl_mem_bytewrite_ram
   import tl_mem_slave_pkg::*;
#(
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic [AW-1:0]                   addr,
   input  logic [TL_DATA_BYTES-1:0]        be,
   input  logic [TL_DATA_BYTES-1:0][7:0]   wdata,
   output logic [TL_DATA_BYTES-1:0][7:0]   rdata
);
   for (genvar g = 0; g < TL_DATA_BYTES; g++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (be[g]) mem[addr] <= wdata[g];
      end

      assign rdata[g] = mem[addr];
   end
endmodule

// File: rtl/tl_mem_slave.sv
// TileLink-UL memory responder: one outstanding transaction, registered D channel,
// denies out-of-window, oversize and unsupported requests.
module tl_mem_slave
   import tl_mem_slave_pkg::*;
#(
   parameter int                      DEPTH     = 256,
   parameter logic [TL_ADDR_BITS-1:0] BASE_ADDR = '0,
   parameter int                      SINK_ID   = 0
) (
   input logic           clk,
   input logic           rst,
   tl_mem_slave_if.slave tl
);
   localparam int WORD_LSB = $clog2(TL_DATA_BYTES);
   localparam int AW       = $clog2(DEPTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   logic [0:0]                 state;
   d_resp_t                    d_q;
   logic                       d_valid;
   logic                       accept;
   logic                       is_get;
   logic                       below_base;
   logic                       out_range;
   logic                       too_big;
   logic                       bad_op;
   logic                       denied;
   logic [TL_ADDR_BITS-1:0]    offset;
   logic [TL_ADDR_BITS-1:0]    word_idx;
   logic [TL_DATA_BYTES-1:0]   be;
   logic [TL_DATA_BYTES*8-1:0] rdata;
   logic                       unused_bits;

   assign d_valid    = (state == S_RESP);
   assign tl.a_ready = !rst && (state == S_IDLE || (d_valid && tl.d_ready));
   assign accept     = tl.a_valid && tl.a_ready;

   assign offset     = tl.a_address - BASE_ADDR;
   assign word_idx   = offset >> WORD_LSB;
   assign is_get     = (tl.a_opcode == A_GET);
   assign below_base = (tl.a_address < BASE_ADDR);
   assign out_range  = (word_idx >= TL_ADDR_BITS'(DEPTH));
   assign too_big    = (tl.a_size > TL_SIZE_BITS'(WORD_LSB));
   assign bad_op     = !(is_get || is_put(tl.a_opcode));
   assign denied     = below_base || out_range || too_big || bad_op;

   // Writes commit on the acceptance edge, so a Get accepted later sees them.
   always_comb begin
      be = '0;
      if (accept && !denied && is_put(tl.a_opcode))
         be = (tl.a_opcode == A_PUT_FULL) ? '1 : tl.a_mask;
   end

   tl_mem_bytewrite_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .addr  (word_idx[AW-1:0]),
      .be    (be),
      .wdata (tl.a_data),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         d_q   <= '0;
      end else if (accept) begin
         state     <= S_RESP;
         d_q.opcode <= is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
         d_q.size   <= tl.a_size;
         d_q.source <= tl.a_source;
         d_q.denied <= denied;
         d_q.data   <= (is_get && !denied) ? rdata : '0;
      end else if (d_valid && tl.d_ready) begin
         state <= S_IDLE;
      end
   end

   assign tl.d_valid  = d_valid;
   assign tl.d_opcode = d_q.opcode;
   assign tl.d_param  = '0;
   assign tl.d_size   = d_q.size;
   assign tl.d_source = d_q.source;
   assign tl.d_sink   = TL_SINK_BITS'(SINK_ID);
   assign tl.d_denied = d_q.denied;
   assign tl.d_data   = d_q.data;

   // Ignored request fields, gathered so they are visibly intentional.
   assign unused_bits = ^{tl.a_param, offset[WORD_LSB-1:0]};
endmodule

// File: tb/tb_tl_mem_slave.sv
// Directed bench for tl_mem_slave: reset, Put/Get data paths, denial cases,
// D-channel backpressure, back-to-back streaming and reset mid-response.
module tb_tl_mem_slave;
   import tl_mem_slave_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   tl_mem_slave_if tl();

   tl_mem_slave #(.DEPTH(256), .BASE_ADDR(32'h1000), .SINK_ID(2)) dut (
      .clk (clk),
      .rst (rst),
      .tl  (tl)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                        input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src);
      tl.a_valid   = 1'b1;
      tl.a_opcode  = op;
      tl.a_param   = 3'd0;
      tl.a_size    = size;
      tl.a_source  = src;
      tl.a_address = addr;
      tl.a_mask    = mask;
      tl.a_data    = data;
   endtask

   // Present one request, wait (bounded) for acceptance, return #1 after the accepting edge.
   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src);
      bit ok = 0;
      drive(op, addr, size, mask, data, src);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tl.a_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      tl.a_valid = 1'b0;
   endtask

   task automatic chk_resp(input string tag, input logic [3:0] op, input logic [3:0] src,
                           input logic den, input logic [31:0] data);
      chk({tag, "_valid"},  {31'd0, tl.d_valid},  32'd1);
      chk({tag, "_opcode"}, {28'd0, tl.d_opcode}, {28'd0, op});
      chk({tag, "_source"}, {28'd0, tl.d_source}, {28'd0, src});
      chk({tag, "_denied"}, {31'd0, tl.d_denied}, {31'd0, den});
      chk({tag, "_data"},   tl.d_data,            data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      tl.d_ready = 1'b1;
      drive(A_PUT_FULL, 32'h1000, 3'd2, 4'hF, 32'h5555_5555, 4'd1);
      #1;
      chk("rst_a_ready", {31'd0, tl.a_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_d_valid",  {31'd0, tl.d_valid},  32'd0);
      chk("rst_d_opcode", {28'd0, tl.d_opcode}, 32'd0);
      chk("rst_d_source", {28'd0, tl.d_source}, 32'd0);
      chk("rst_d_denied", {31'd0, tl.d_denied}, 32'd0);
      chk("rst_d_data",   tl.d_data,            32'd0);
      chk("rst_d_size",   {29'd0, tl.d_size},   32'd0);
      chk("rst_d_param",  {30'd0, tl.d_param},  32'd0);
      chk("rst_d_sink",   {30'd0, tl.d_sink},   32'd2);
      tl.a_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_a_ready", {31'd0, tl.a_ready}, 32'd1);
      @(posedge clk); #1;
      chk("post_rst_no_resp", {31'd0, tl.d_valid}, 32'd0);

      // Basic Put/Get and partial write merge
      do_req(A_PUT_FULL, 32'h1010, 3'd2, 4'hF, 32'hDEAD_BEEF, 4'd3);
      chk_resp("putfull", D_ACCESS_ACK, 4'd3, 1'b0, 32'd0);
      chk("putfull_size", {29'd0, tl.d_size}, 32'd2);
      do_req(A_GET, 32'h1010, 3'd2, 4'hF, 32'd0, 4'd5);
      chk_resp("get1", D_ACCESS_ACK_DATA, 4'd5, 1'b0, 32'hDEAD_BEEF);
      do_req(A_PUT_PARTIAL, 32'h1012, 3'd2, 4'b0101, 32'h1122_3344, 4'd4);
      chk_resp("putpart", D_ACCESS_ACK, 4'd4, 1'b0, 32'd0);
      do_req(A_GET, 32'h1010, 3'd2, 4'hF, 32'd0, 4'd5);
      chk_resp("get_merge", D_ACCESS_ACK_DATA, 4'd5, 1'b0, 32'hDE22_BE44);
      do_req(A_PUT_PARTIAL, 32'h1010, 3'd2, 4'b0000, 32'hFFFF_FFFF, 4'd6);
      chk_resp("mask0", D_ACCESS_ACK, 4'd6, 1'b0, 32'd0);
      do_req(A_GET, 32'h1010, 3'd2, 4'hF, 32'd0, 4'd5);
      chk_resp("get_mask0", D_ACCESS_ACK_DATA, 4'd5, 1'b0, 32'hDE22_BE44);

      // Denials
      do_req(A_PUT_FULL, 32'h1000, 3'd2, 4'hF, 32'hCAFE_F00D, 4'd1);
      chk_resp("put_w0", D_ACCESS_ACK, 4'd1, 1'b0, 32'd0);
      do_req(A_GET, 32'h0FFC, 3'd2, 4'hF, 32'd0, 4'd2);
      chk_resp("den_low", D_ACCESS_ACK_DATA, 4'd2, 1'b1, 32'd0);
      do_req(A_GET, 32'h1400, 3'd2, 4'hF, 32'd0, 4'd2);
      chk_resp("den_high", D_ACCESS_ACK_DATA, 4'd2, 1'b1, 32'd0);
      do_req(A_GET, 32'h1010, 3'd3, 4'hF, 32'd0, 4'd2);
      chk_resp("den_size", D_ACCESS_ACK_DATA, 4'd2, 1'b1, 32'd0);
      do_req(A_PUT_FULL, 32'h1400, 3'd2, 4'hF, 32'h0BAD_0BAD, 4'd8);
      chk_resp("den_put", D_ACCESS_ACK, 4'd8, 1'b1, 32'd0);
      do_req(3'd2, 32'h1000, 3'd2, 4'hF, 32'h0BAD_0BAD, 4'd9);
      chk_resp("den_op", D_ACCESS_ACK, 4'd9, 1'b1, 32'd0);
      do_req(A_GET, 32'h1000, 3'd2, 4'hF, 32'd0, 4'd1);
      chk_resp("w0_intact", D_ACCESS_ACK_DATA, 4'd1, 1'b0, 32'hCAFE_F00D);
      do_req(A_GET, 32'h13FC, 3'd2, 4'hF, 32'd0, 4'd1);
      chk("last_word_ok", {31'd0, tl.d_denied}, 32'd0);

      // Backpressure on D
      @(posedge clk); #1;
      tl.d_ready = 1'b0;
      do_req(A_GET, 32'h1010, 3'd2, 4'hF, 32'd0, 4'd6);
      drive(A_GET, 32'h1000, 3'd2, 4'hF, 32'd0, 4'd7);
      for (int i = 0; i < 5; i++) begin
         chk_resp("stall", D_ACCESS_ACK_DATA, 4'd6, 1'b0, 32'hDE22_BE44);
         chk("stall_a_ready", {31'd0, tl.a_ready}, 32'd0);
         @(posedge clk); #1;
      end
      tl.d_ready = 1'b1;
      #1;
      chk("release_a_ready", {31'd0, tl.a_ready}, 32'd1);
      @(posedge clk); #1;
      tl.a_valid = 1'b0;
      chk_resp("release", D_ACCESS_ACK_DATA, 4'd7, 1'b0, 32'hCAFE_F00D);
      @(posedge clk); #1;
      chk("drained", {31'd0, tl.d_valid}, 32'd0);

      // Back-to-back: 8 Puts then 8 Gets, one per cycle
      drive(A_PUT_FULL, 32'h1040, 3'd2, 4'hF, 32'hA500_0000, 4'd0);
      for (int k = 0; k < 16; k++) begin
         #3;
         chk("b2b_a_ready", {31'd0, tl.a_ready}, 32'd1);
         @(posedge clk); #1;
         if (k < 8)
            chk_resp("b2b_put", D_ACCESS_ACK, 4'(k), 1'b0, 32'd0);
         else
            chk_resp("b2b_get", D_ACCESS_ACK_DATA, 4'(k), 1'b0, 32'hA500_0000 | 32'(k - 8));
         if (k < 7)
            drive(A_PUT_FULL, 32'h1040 + 32'(4 * (k + 1)), 3'd2, 4'hF, 32'hA500_0000 | 32'(k + 1), 4'(k + 1));
         else if (k < 15)
            drive(A_GET, 32'h1040 + 32'(4 * (k - 7)), 3'd2, 4'hF, 32'd0, 4'(k + 1));
         else
            tl.a_valid = 1'b0;
      end
      @(posedge clk); #1;

      // Reset while a response is pending
      tl.d_ready = 1'b0;
      do_req(A_PUT_FULL, 32'h1080, 3'd2, 4'hF, 32'h1234_5678, 4'd3);
      chk("mid_pending", {31'd0, tl.d_valid}, 32'd1);
      rst = 1'b1;
      drive(A_PUT_FULL, 32'h1080, 3'd2, 4'hF, 32'hFFFF_0000, 4'd4);
      #1;
      chk("mid_rst_a_ready", {31'd0, tl.a_ready}, 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_d_valid", {31'd0, tl.d_valid}, 32'd0);
      tl.a_valid = 1'b0;
      rst = 1'b0;
      tl.d_ready = 1'b1;
      do_req(A_GET, 32'h1080, 3'd2, 4'hF, 32'd0, 4'd5);
      chk_resp("survive", D_ACCESS_ACK_DATA, 4'd5, 1'b0, 32'h1234_5678);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
